// File: rtl/irq_cond_pkg.sv
// Shared definitions for the interrupt conditioner: register map, defaults, channel mode.
package irq_cond_pkg;

  localparam int FILT_W_DEF = 8;

  // Word offsets decoded from paddr[7:2]
  localparam logic [5:0] OFF_ENABLE   = 6'd0;
  localparam logic [5:0] OFF_POLARITY = 6'd1;
  localparam logic [5:0] OFF_EDGE     = 6'd2;
  localparam logic [5:0] OFF_BOTHEDGE = 6'd3;
  localparam logic [5:0] OFF_FILTER   = 6'd4;
  localparam logic [5:0] OFF_STATE    = 6'd5;

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'd0,
    MODE_RISE  = 2'd1,
    MODE_BOTH  = 2'd2
  } irq_mode_e;

  // BOTHEDGE only matters once EDGE is set
  function automatic irq_mode_e chan_mode(input logic edge_en, input logic both_en);
    if (!edge_en) return MODE_LEVEL;
    return both_en ? MODE_BOTH : MODE_RISE;
  endfunction

endpackage

// File: rtl/irq_cond_chan.sv
// One interrupt channel: synchroniser, polarity, glitch filter, edge detect, output flop.
module irq_cond_chan
  import irq_cond_pkg::*;
#(
  parameter int FILT_W      = FILT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              raw_i,
  input  logic              en_i,
  input  logic              pol_i,
  input  logic              edge_i,
  input  logic              both_i,
  input  logic [FILT_W-1:0] filter_i,
  input  logic              pol_wr_i,   // polarity of this channel is changing this cycle
  input  logic              pol_new_i,  // polarity value being written
  output logic              state_o,
  output logic              irq_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   f_q, f_d, fp_q, irq_q, irq_d;
  logic                   s;
  irq_mode_e              mode;

  assign s       = sync_q[SYNC_STAGES-1] ^ pol_i;
  assign mode    = chan_mode(edge_i, both_i);
  assign state_o = f_q;
  assign irq_o   = irq_q;

  // Filter: level must differ from f for more than filter_i cycles before f moves.
  // A polarity change re-seeds f with the new polarised level so no edge is seen.
  always_comb begin
    f_d   = f_q;
    cnt_d = cnt_q;
    if (pol_wr_i) begin
      f_d   = sync_q[SYNC_STAGES-1] ^ pol_new_i;
      cnt_d = '0;
    end else if (s == f_q) begin
      cnt_d = '0;
    end else if (cnt_q >= filter_i) begin
      f_d   = s;
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + FILT_W'(1);
    end
  end

  // Output selection by mode; enable masks only the output, not the tracking state
  always_comb begin
    irq_d = 1'b0;
    case (mode)
      MODE_LEVEL: irq_d = f_q;
      MODE_RISE:  irq_d = f_q & ~fp_q;
      MODE_BOTH:  irq_d = f_q ^ fp_q;
      default:    irq_d = 1'b0;
    endcase
    irq_d = irq_d & en_i;
  end

  // Synchroniser, filter, previous-level and output registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      f_q    <= 1'b0;
      fp_q   <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q  <= cnt_d;
      f_q    <= f_d;
      fp_q   <= pol_wr_i ? f_d : f_q;
      irq_q  <= irq_d;
    end
  end

endmodule

// File: rtl/irq_conditioner.sv
// Interrupt conditioner top: APB3 config registers, read mux, array of channels.
module irq_conditioner
  import irq_cond_pkg::*;
#(
  parameter int NUM_IRQ     = 32,
  parameter int FILT_W      = FILT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               psel_i,
  input  logic               penable_i,
  input  logic [31:0]        paddr_i,
  input  logic [31:0]        pwdata_i,
  input  logic               pwrite_i,
  output logic [31:0]        prdata_o,
  output logic               pready_o,
  output logic               pslverr_o,
  input  logic [NUM_IRQ-1:0] irq_raw_i,
  output logic [NUM_IRQ-1:0] irqs_o
);

  logic [NUM_IRQ-1:0] enable_q, pol_q, edge_q, both_q, state;
  logic [FILT_W-1:0]  filter_q;
  logic [31:0]        prdata_q, rdata;
  logic [5:0]         off;
  logic               wr_en, rd_en, pol_wr;
  logic               unused_paddr;

  assign off          = paddr_i[7:2];
  assign wr_en        = psel_i & penable_i & pwrite_i;
  assign rd_en        = psel_i & ~penable_i & ~pwrite_i;
  assign pol_wr       = wr_en && (off == OFF_POLARITY);
  assign pready_o     = 1'b1;
  assign pslverr_o    = 1'b0;
  assign prdata_o     = prdata_q;
  assign unused_paddr = ^{paddr_i[31:8], paddr_i[1:0]};

  // Config register writes; STATE and unmapped offsets ignore writes
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      enable_q <= '0;
      pol_q    <= '0;
      edge_q   <= '0;
      both_q   <= '0;
      filter_q <= '0;
    end else if (wr_en) begin
      case (off)
        OFF_ENABLE:   enable_q <= pwdata_i[NUM_IRQ-1:0];
        OFF_POLARITY: pol_q    <= pwdata_i[NUM_IRQ-1:0];
        OFF_EDGE:     edge_q   <= pwdata_i[NUM_IRQ-1:0];
        OFF_BOTHEDGE: both_q   <= pwdata_i[NUM_IRQ-1:0];
        OFF_FILTER:   filter_q <= pwdata_i[FILT_W-1:0];
        default: ;
      endcase
    end
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    rdata = '0;
    case (off)
      OFF_ENABLE:   rdata = 32'(enable_q);
      OFF_POLARITY: rdata = 32'(pol_q);
      OFF_EDGE:     rdata = 32'(edge_q);
      OFF_BOTHEDGE: rdata = 32'(both_q);
      OFF_FILTER:   rdata = 32'(filter_q);
      OFF_STATE:    rdata = 32'(state);
      default:      rdata = '0;
    endcase
  end

  // Read data captured in the setup phase, cleared otherwise
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) prdata_q <= '0;
    else         prdata_q <= rd_en ? rdata : '0;
  end

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
    irq_cond_chan #(
      .FILT_W      (FILT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .raw_i     (irq_raw_i[g]),
      .en_i      (enable_q[g]),
      .pol_i     (pol_q[g]),
      .edge_i    (edge_q[g]),
      .both_i    (both_q[g]),
      .filter_i  (filter_q),
      .pol_wr_i  (pol_wr && (pwdata_i[g] != pol_q[g])),
      .pol_new_i (pwdata_i[g]),
      .state_o   (state[g]),
      .irq_o     (irqs_o[g])
    );
  end

endmodule

// File: tb/tb_irq_conditioner.sv
// Directed bench for irq_conditioner; inputs driven and outputs sampled on negedges.
module tb_irq_conditioner;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        psel_i, penable_i, pwrite_i;
  logic [31:0] paddr_i, pwdata_i, prdata_o;
  logic        pready_o, pslverr_o;
  logic [31:0] irq_raw_i, irqs_o;

  int checks = 0;
  int errors = 0;

  irq_conditioner #(.NUM_IRQ(32), .FILT_W(8), .SYNC_STAGES(2)) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .psel_i    (psel_i),
    .penable_i (penable_i),
    .paddr_i   (paddr_i),
    .pwdata_i  (pwdata_i),
    .pwrite_i  (pwrite_i),
    .prdata_o  (prdata_o),
    .pready_o  (pready_o),
    .pslverr_o (pslverr_o),
    .irq_raw_i (irq_raw_i),
    .irqs_o    (irqs_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the access phase
  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = addr; pwdata_i = data;
    @(negedge clk_i); penable_i = 1'b1;
    @(negedge clk_i); psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = addr;
    @(negedge clk_i); penable_i = 1'b1; data = prdata_o;
    @(negedge clk_i); psel_i = 1'b0; penable_i = 1'b0;
  endtask

  task automatic count_pulses(input int b, input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk_i);
      if (irqs_o[b]) c++;
    end
  endtask

  initial begin
    logic [31:0] rd;
    int cnt;
    logic seen;

    rstn_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; irq_raw_i = '0;
    repeat (2) @(negedge clk_i);
    chk("reset_irqs", irqs_o, 32'h0);
    chk("reset_prdata", prdata_o, 32'h0);
    chk("pready", {30'b0, pready_o, pslverr_o}, 32'h2);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // APB register access
    apb_write(32'h00, 32'hA5A5_A5A5);
    apb_read(32'h00, rd);  chk("enable_rb", rd, 32'hA5A5_A5A5);
    apb_read(32'h18, rd);  chk("unmapped_18", rd, 32'h0);
    apb_read(32'hFC, rd);  chk("unmapped_fc", rd, 32'h0);
    apb_write(32'h14, 32'hFFFF_FFFF);
    apb_read(32'h14, rd);  chk("state_ro", rd, 32'h0);
    apb_write(32'h10, 32'h0000_01FF);
    apb_read(32'h10, rd);  chk("filter_width", rd, 32'h0000_00FF);
    apb_write(32'h10, 32'h0);

    // Level mode, FILTER=0: output 4 edges after raw change
    apb_write(32'h00, 32'h0000_0008);
    irq_raw_i[3] = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("lvl_edge3", 32'(irqs_o[3]), 32'h0);
    @(negedge clk_i);
    chk("lvl_edge4", 32'(irqs_o[3]), 32'h1);
    repeat (5) @(negedge clk_i);
    chk("lvl_hold", irqs_o, 32'h0000_0008);
    irq_raw_i[3] = 1'b0;
    repeat (6) @(negedge clk_i);
    chk("lvl_release", irqs_o, 32'h0);

    // Enable masks output only; re-enable mid-level asserts one cycle after the write
    apb_write(32'h00, 32'h0);
    irq_raw_i[3] = 1'b1;
    repeat (6) @(negedge clk_i);
    chk("masked", irqs_o, 32'h0);
    apb_write(32'h00, 32'h0000_0008);
    @(negedge clk_i);
    chk("reenable", 32'(irqs_o[3]), 32'h1);
    irq_raw_i[3] = 1'b0;
    apb_write(32'h00, 32'h0000_0001);
    repeat (6) @(negedge clk_i);

    // Glitch filter, FILTER=5: 5-cycle pulse dropped, 6-cycle pulse passes
    apb_write(32'h10, 32'h5);
    irq_raw_i[0] = 1'b1;
    repeat (5) @(negedge clk_i);
    irq_raw_i[0] = 1'b0;
    seen = 1'b0;
    repeat (14) begin
      @(negedge clk_i);
      if (irqs_o[0]) seen = 1'b1;
    end
    chk("filt_drop5", 32'(seen), 32'h0);
    irq_raw_i[0] = 1'b1;
    repeat (6) @(negedge clk_i);
    irq_raw_i[0] = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("filt_pre", 32'(irqs_o[0]), 32'h0);
    apb_read(32'h14, rd);  chk("filt_state6", rd, 32'h0000_0001);
    chk("filt_out6", 32'(irqs_o[0]), 32'h1);
    repeat (14) @(negedge clk_i);
    chk("filt_fall", irqs_o, 32'h0);
    apb_write(32'h10, 32'h0);

    // Rising-edge mode on channel 7
    apb_write(32'h00, 32'h0000_0080);
    apb_write(32'h08, 32'h0000_0080);
    irq_raw_i[7] = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rise_e3", 32'(irqs_o[7]), 32'h0);
    @(negedge clk_i);
    chk("rise_e4", 32'(irqs_o[7]), 32'h1);
    @(negedge clk_i);
    chk("rise_e5", 32'(irqs_o[7]), 32'h0);
    count_pulses(7, 6, cnt);  chk("rise_hold", 32'(cnt), 32'h0);
    irq_raw_i[7] = 1'b0;
    count_pulses(7, 8, cnt);  chk("rise_fall_none", 32'(cnt), 32'h0);

    // Both-edge mode: one pulse per transition, consecutive pulses for fast toggles
    apb_write(32'h0C, 32'h0000_0080);
    irq_raw_i[7] = 1'b1;
    count_pulses(7, 8, cnt);  chk("both_rise", 32'(cnt), 32'h1);
    irq_raw_i[7] = 1'b0;
    count_pulses(7, 8, cnt);  chk("both_fall", 32'(cnt), 32'h1);
    cnt = 0;
    for (int k = 0; k < 14; k++) begin
      if (k < 4) irq_raw_i[7] = (k % 2 == 0);
      @(negedge clk_i);
      if (irqs_o[7]) cnt++;
    end
    chk("both_toggle", 32'(cnt), 32'h4);

    // Polarity change must not fake an edge
    apb_write(32'h0C, 32'h0);
    apb_write(32'h08, 32'h0000_0004);
    apb_write(32'h00, 32'h0000_0004);
    apb_write(32'h04, 32'h0000_0004);
    count_pulses(2, 8, cnt);  chk("pol_no_pulse", 32'(cnt), 32'h0);
    irq_raw_i[2] = 1'b1;
    count_pulses(2, 8, cnt);  chk("pol_deassert", 32'(cnt), 32'h0);
    irq_raw_i[2] = 1'b0;
    count_pulses(2, 8, cnt);  chk("pol_assert", 32'(cnt), 32'h1);

    // Reset in the middle of activity
    apb_write(32'h04, 32'h0);
    apb_write(32'h08, 32'h0);
    apb_write(32'h00, 32'hFFFF_FFFF);
    irq_raw_i = 32'hFFFF_FFFF;
    repeat (6) @(negedge clk_i);
    chk("all_active", irqs_o, 32'hFFFF_FFFF);
    rstn_i = 1'b0;
    #1;
    chk("midrst_irqs", irqs_o, 32'h0);
    chk("midrst_prdata", prdata_o, 32'h0);
    repeat (3) @(negedge clk_i);
    chk("inrst_irqs", irqs_o, 32'h0);
    rstn_i = 1'b1;
    apb_read(32'h14, rd);  chk("postrst_state", rd, 32'h0);
    apb_read(32'h00, rd);  chk("postrst_enable", rd, 32'h0);
    repeat (4) @(negedge clk_i);
    chk("postrst_irqs", irqs_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
